// File: rtl/ps2_key_sequencer.sv
// PS/2 break-code sequencer: tracks F0/E0 prefixes, maps released keys to command
// codes and queues them in a first-word fall-through FIFO for the RTC controller.
module ps2_key_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       rx_done_tick,
  input  logic [7:0] dout,
  input  logic       rd_ack,
  input  logic       clr_ovf,
  output logic       rx_en,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic [4:0] count,
  output logic       overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    BRK_BYTE = 8'hF0;
  localparam logic [7:0]    EXT_BYTE = 8'hE0;
  localparam logic [4:0]    FULL_CNT = 5'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_e;

  // Scan code to command code; bit 8 flags a hit.
  function automatic logic [8:0] map_scan(input logic [7:0] scan);
    logic [8:0] r;
    case (scan)
      8'h2B:   r = {1'b1, 8'h01};
      8'h33:   r = {1'b1, 8'h02};
      8'h2C:   r = {1'b1, 8'h03};
      8'h75:   r = {1'b1, 8'h10};
      8'h74:   r = {1'b1, 8'h11};
      8'h6B:   r = {1'b1, 8'h12};
      8'h72:   r = {1'b1, 8'h13};
      8'h76:   r = {1'b1, 8'h1F};
      default: r = {1'b0, 8'h00};
    endcase
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            req_q, req_d;
  logic [7:0]      scan_q, scan_d;
  logic [8:0]      lookup_s;
  logic            lk_hit_q;
  logic [7:0]      lk_code_q;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic [7:0]      head_q, head_d;
  logic            ovf_q, ovf_d;
  logic            rx_en_q;
  logic            do_pop_s, do_push_s, drop_s;

  assign lookup_s = map_scan(scan_q);

  // Prefix tracking and inter-byte timeout; a byte after a break prefix raises a lookup request.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    req_d   = 1'b0;
    scan_d  = scan_q;
    if (!enable) begin
      state_d = S_IDLE;
      tmo_d   = '0;
    end else if (rx_done_tick) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (dout == BRK_BYTE) begin
            state_d = S_BRK;
          end else if (dout == EXT_BYTE) begin
            state_d = S_EXT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_EXT: begin
          if (dout == BRK_BYTE) begin
            state_d = S_EXT_BRK;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_BRK, S_EXT_BRK: begin
          req_d   = 1'b1;
          scan_d  = dout;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d = S_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end

  // FIFO bookkeeping; the head register is refreshed from whatever entry becomes the head.
  always_comb begin
    do_pop_s  = rd_ack && (cnt_q != 5'd0);
    do_push_s = lk_hit_q && ((cnt_q != FULL_CNT) || do_pop_s);
    drop_s    = lk_hit_q && (cnt_q == FULL_CNT) && !do_pop_s;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    head_d    = head_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + 5'd1;
      2'b01:   cnt_d = cnt_q - 5'd1;
      default: cnt_d = cnt_q;
    endcase
    // An entry written this edge that lands on the head is not yet in mem_q.
    if (cnt_d == 5'd0) begin
      head_d = head_q;
    end else if (do_push_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = lk_code_q;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
    valid_d = (cnt_d != 5'd0);
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Sequencer, lookup pipeline and FIFO control registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      tmo_q     <= '0;
      req_q     <= 1'b0;
      scan_q    <= 8'h00;
      lk_hit_q  <= 1'b0;
      lk_code_q <= 8'h00;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= 5'd0;
      valid_q   <= 1'b0;
      head_q    <= 8'h00;
      ovf_q     <= 1'b0;
      rx_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      req_q     <= req_d;
      scan_q    <= scan_d;
      lk_hit_q  <= req_q && lookup_s[8];
      lk_code_q <= lookup_s[7:0];
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      head_q    <= head_d;
      ovf_q     <= ovf_d;
      rx_en_q   <= enable;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (reset && do_push_s) begin
      mem_q[wr_ptr_q] <= lk_code_q;
    end
  end

  assign rx_en     = rx_en_q;
  assign key_code  = head_q;
  assign key_valid = valid_q;
  assign count     = cnt_q;
  assign overflow  = ovf_q;

endmodule
